// File: rtl/arb_req_pkg.sv
// Shared types and constants for the round-robin arbiter requester agent.
// Holds the requester state encoding and a saturating counter helper.
package arb_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_DRAIN   = 2;
    localparam int GRANT_CNT_W     = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
        if (v == {GRANT_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + GRANT_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/arb_req_watchdog.sv
// No-grant watchdog: while armed, counts consecutive un-kicked cycles down
// from TIMEOUT-1 and pulses expire on the TIMEOUT-th one. A kick reloads it.
module arb_req_watchdog
    import arb_req_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic arm,
    input  logic kick,
    output logic expire
);

    localparam int          CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and expiry; a kick in the expiry cycle suppresses the expiry.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (arm && !kick) begin
            if (cnt_q == {CW{1'b0}}) begin
                expire = 1'b1;
                cnt_d  = LOAD;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else begin
            cnt_d = LOAD;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Requester agent for one port of the two-input round-robin arbiter: accepts
// burst jobs, holds req until all beats are acked (or the watchdog fires), then drains.
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int LEN_W     = 4,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int DRAIN_CYC = DEFAULT_DRAIN
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   job_valid,
    input  logic [LEN_W-1:0]       job_len,
    output logic                   job_ready,
    output logic                   req,
    input  logic                   ack,
    output logic                   beat_valid,
    output logic [LEN_W-1:0]       beat_idx,
    output logic                   done,
    output logic                   timeout,
    output logic [GRANT_CNT_W-1:0] grant_cnt
);

    localparam int             DW         = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         remaining_q, remaining_d;
    logic [LEN_W-1:0]         idx_cnt_q, idx_cnt_d;
    logic [DW-1:0]            drain_q, drain_d;
    logic                     job_ready_q, job_ready_d;
    logic                     req_q, req_d;
    logic                     beat_valid_q, beat_valid_d;
    logic [LEN_W-1:0]         beat_idx_q, beat_idx_d;
    logic                     done_q, done_d;
    logic                     timeout_q, timeout_d;
    logic [GRANT_CNT_W-1:0]   grant_cnt_q, grant_cnt_d;
    logic                     wd_arm_s;
    logic                     wd_expire_s;

    assign wd_arm_s = (state_q == REQ);

    arb_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .arm     (wd_arm_s),
        .kick    (ack),
        .expire  (wd_expire_s)
    );

    // Next-state and output computation; acks count only while in REQ.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        idx_cnt_d    = idx_cnt_q;
        drain_d      = drain_q;
        beat_valid_d = 1'b0;
        beat_idx_d   = beat_idx_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        grant_cnt_d  = grant_cnt_q;
        case (state_q)
            IDLE: begin
                if (job_valid && job_ready_q) begin
                    remaining_d = job_len;
                    idx_cnt_d   = LEN_ZERO;
                    beat_idx_d  = LEN_ZERO;
                    if (job_len == LEN_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack) begin
                    beat_valid_d = 1'b1;
                    beat_idx_d   = idx_cnt_q;
                    idx_cnt_d    = idx_cnt_q + LEN_ONE;
                    remaining_d  = remaining_q - LEN_ONE;
                    grant_cnt_d  = sat_inc(grant_cnt_q);
                    if (remaining_q == LEN_ONE) begin
                        done_d  = 1'b1;
                        state_d = DRAIN;
                        drain_d = DRAIN_LAST;
                    end else begin
                        state_d = REQ;
                    end
                end else if (wd_expire_s) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                    drain_d   = DRAIN_LAST;
                end else begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // Stale acks from the arbiter's latched request land here and are dropped.
                if (drain_q == {DW{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        job_ready_d = (state_d == IDLE);
        req_d       = (state_d == REQ);
    end

    // State and registered-output flops with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remaining_q  <= LEN_ZERO;
            idx_cnt_q    <= LEN_ZERO;
            drain_q      <= {DW{1'b0}};
            job_ready_q  <= 1'b0;
            req_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_idx_q   <= LEN_ZERO;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            grant_cnt_q  <= {GRANT_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            idx_cnt_q    <= idx_cnt_d;
            drain_q      <= drain_d;
            job_ready_q  <= job_ready_d;
            req_q        <= req_d;
            beat_valid_q <= beat_valid_d;
            beat_idx_q   <= beat_idx_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign job_ready  = job_ready_q;
    assign req        = req_q;
    assign beat_valid = beat_valid_q;
    assign beat_idx   = beat_idx_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign grant_cnt  = grant_cnt_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: two instances behind a small round-robin arbiter
// model, with a bench-driven ack path for single-requester scenarios.
module tb_arb_requester;

    logic        clock;
    logic        reset_n;
    logic        jv0, jv1, jr0, jr1, req0, req1, ack0, ack1;
    logic [3:0]  jl0, jl1, bi0, bi1;
    logic        bv0, bv1, done0, done1, to0, to1;
    logic [15:0] gc0, gc1;
    logic        arb_mode, drv_ack0;
    logic        lr0, lr1, arb_ack0, arb_ack1, pri, g0, g1;

    int tests_run = 0;
    int fails = 0;
    int exp_gc0 = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] e0, e1;

    arb_requester u0 (
        .clock(clock), .reset_n(reset_n), .job_valid(jv0), .job_len(jl0), .job_ready(jr0),
        .req(req0), .ack(ack0), .beat_valid(bv0), .beat_idx(bi0), .done(done0),
        .timeout(to0), .grant_cnt(gc0)
    );
    arb_requester u1 (
        .clock(clock), .reset_n(reset_n), .job_valid(jv1), .job_len(jl1), .job_ready(jr1),
        .req(req1), .ack(ack1), .beat_valid(bv1), .beat_idx(bi1), .done(done1),
        .timeout(to1), .grant_cnt(gc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ack0 = arb_mode ? arb_ack0 : drv_ack0;
    assign ack1 = arb_mode ? arb_ack1 : 1'b0;

    // Arbiter model: requests latched one cycle, ack registered the next; pri=1 favours port 0.
    assign g0 = lr0 & (~lr1 | pri);
    assign g1 = lr1 & (~lr0 | ~pri);
    always @(posedge clock) begin
        if (!reset_n) begin
            lr0 <= 1'b0; lr1 <= 1'b0; arb_ack0 <= 1'b0; arb_ack1 <= 1'b0; pri <= 1'b1;
        end else begin
            lr0 <= req0; lr1 <= req1;
            arb_ack0 <= g0; arb_ack1 <= g1;
            if (g0) pri <= 1'b0;
            else if (g1) pri <= 1'b1;
        end
    end

    // Scoreboard: each observed beat pops the expected index for its instance.
    always @(negedge clock) begin
        if (reset_n && bv0) begin
            tests_run++;
            if (q0.size() == 0) begin
                fails++; $display("FAIL sb_beat0: got unexpected beat idx %0d, expected none", bi0);
            end else begin
                e0 = q0.pop_front();
                if (bi0 !== e0) begin fails++; $display("FAIL sb_beat0: got idx %0d expected %0d", bi0, e0); end
            end
        end
        if (reset_n && bv1) begin
            tests_run++;
            if (q1.size() == 0) begin
                fails++; $display("FAIL sb_beat1: got unexpected beat idx %0d, expected none", bi1);
            end else begin
                e1 = q1.pop_front();
                if (bi1 !== e1) begin fails++; $display("FAIL sb_beat1: got idx %0d expected %0d", bi1, e1); end
            end
        end
    end

    task automatic start_job0(input logic [3:0] len);
        jv0 = 1'b1; jl0 = len;
        for (int i = 0; i < int'(len); i++) q0.push_back(4'(i));
        @(negedge clock);
        jv0 = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({req0, jr0, bv0, done0, to0} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got req/rdy/bv/done/to=%05b expected 00000", {req0, jr0, bv0, done0, to0});
        end
        tests_run++;
        if (bi0 !== 4'd0 || gc0 !== 16'd0) begin
            fails++; $display("FAIL reset_cnt: got idx %0d gc %0d expected 0 0", bi0, gc0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        tests_run++;
        if (jr0 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", jr0); end
    endtask

    task automatic test_single;
        int beats = 0, dones = 0, first = -1, last = -1;
        start_job0(4'd3);
        tests_run++;
        if (req0 !== 1'b1) begin fails++; $display("FAIL single_req: got %0b expected 1", req0); end
        @(negedge clock);
        drv_ack0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bv0) begin beats++; if (first < 0) first = i; last = i; end
            if (done0) begin
                dones++;
                tests_run++;
                if (!(bv0 && bi0 == 4'd2 && req0 == 1'b0)) begin
                    fails++; $display("FAIL single_done: got bv %0b idx %0d req %0b expected 1 2 0", bv0, bi0, req0);
                end
            end
        end
        drv_ack0 = 1'b0;
        exp_gc0 += 3;
        tests_run++;
        if (beats != 3 || last - first != 2) begin
            fails++; $display("FAIL single_beats: got %0d beats span %0d expected 3 span 2", beats, last - first);
        end
        tests_run++;
        if (dones != 1) begin fails++; $display("FAIL single_done_cnt: got %0d expected 1", dones); end
        tests_run++;
        if (gc0 !== 16'(exp_gc0)) begin fails++; $display("FAIL single_gc: got %0d expected %0d", gc0, exp_gc0); end
    endtask

    task automatic test_zero_len;
        start_job0(4'd0);
        drv_ack0 = 1'b1;
        tests_run++;
        if (done0 !== 1'b1 || req0 !== 1'b0 || jr0 !== 1'b1) begin
            fails++; $display("FAIL zero_done: got done %0b req %0b rdy %0b expected 1 0 1", done0, req0, jr0);
        end
        repeat (2) @(negedge clock);
        drv_ack0 = 1'b0;
        tests_run++;
        if (done0 !== 1'b0 || req0 !== 1'b0 || bv0 !== 1'b0) begin
            fails++; $display("FAIL zero_after: got done %0b req %0b bv %0b expected 0 0 0", done0, req0, bv0);
        end
        tests_run++;
        if (gc0 !== 16'(exp_gc0)) begin fails++; $display("FAIL zero_gc: got %0d expected %0d", gc0, exp_gc0); end
    endtask

    task automatic test_stale_ack;
        start_job0(4'd1);
        drv_ack0 = 1'b1;
        @(negedge clock);
        tests_run++;
        if (bv0 !== 1'b1 || done0 !== 1'b1 || req0 !== 1'b0) begin
            fails++; $display("FAIL stale_final: got bv %0b done %0b req %0b expected 1 1 0", bv0, done0, req0);
        end
        @(negedge clock);
        drv_ack0 = 1'b0;
        tests_run++;
        if (bv0 !== 1'b0) begin fails++; $display("FAIL stale_beat: got bv %0b expected 0", bv0); end
        exp_gc0 += 1;
        repeat (2) @(negedge clock);
        tests_run++;
        if (gc0 !== 16'(exp_gc0)) begin fails++; $display("FAIL stale_gc: got %0d expected %0d", gc0, exp_gc0); end
    endtask

    task automatic test_timeout;
        int req_cyc = 0, tos = 0, dones = 0, beats = 0, to_cyc = -1, jr_cyc = -1;
        drv_ack0 = 1'b0;
        start_job0(4'd2);
        if (req0) req_cyc++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (req0) req_cyc++;
            if (bv0) beats++;
            if (done0) dones++;
            if (to0) begin tos++; to_cyc = i; end
            if (jr0 && to_cyc >= 0 && jr_cyc < 0) jr_cyc = i;
        end
        q0.delete();
        tests_run++;
        if (req_cyc != 16) begin fails++; $display("FAIL to_req_len: got %0d expected 16", req_cyc); end
        tests_run++;
        if (tos != 1 || dones != 0 || beats != 0) begin
            fails++; $display("FAIL to_pulses: got to %0d done %0d beats %0d expected 1 0 0", tos, dones, beats);
        end
        tests_run++;
        if (jr_cyc - to_cyc != 2) begin fails++; $display("FAIL to_ready: got gap %0d expected 2", jr_cyc - to_cyc); end
        tests_run++;
        if (gc0 !== 16'(exp_gc0)) begin fails++; $display("FAIL to_gc: got %0d expected %0d", gc0, exp_gc0); end
    endtask

    task automatic test_two_instances;
        int b0 = 0, b1 = 0, d0 = 0, d1 = 0, both = 0, alt_err = 0, owner = -1;
        arb_mode = 1'b1;
        jv0 = 1'b1; jl0 = 4'd4; jv1 = 1'b1; jl1 = 4'd4;
        for (int i = 0; i < 4; i++) begin q0.push_back(4'(i)); q1.push_back(4'(i)); end
        @(negedge clock);
        jv0 = 1'b0; jv1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bv0 && bv1) both++;
            if (bv0) begin b0++; if (owner == 0) alt_err++; owner = 0; end
            if (bv1) begin b1++; if (owner == 1) alt_err++; owner = 1; end
            if (done0) d0++;
            if (done1) d1++;
        end
        arb_mode = 1'b0;
        exp_gc0 += 4;
        tests_run++;
        if (b0 != 4 || b1 != 4) begin fails++; $display("FAIL dual_beats: got %0d/%0d expected 4/4", b0, b1); end
        tests_run++;
        if (both != 0) begin fails++; $display("FAIL dual_mutex: got %0d overlaps expected 0", both); end
        tests_run++;
        if (alt_err != 0) begin fails++; $display("FAIL dual_alternate: got %0d repeats expected 0", alt_err); end
        tests_run++;
        if (d0 != 1 || d1 != 1) begin fails++; $display("FAIL dual_done: got %0d/%0d expected 1/1", d0, d1); end
        tests_run++;
        if (gc0 !== 16'(exp_gc0) || gc1 !== 16'd4) begin
            fails++; $display("FAIL dual_gc: got %0d/%0d expected %0d/4", gc0, gc1, exp_gc0);
        end
    endtask

    task automatic test_reset_mid;
        int found = 0, beats = 0, dones = 0, tos = 0;
        start_job0(4'd4);
        drv_ack0 = 1'b1;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clock);
            if (bv0 && bi0 == 4'd1) found = 1;
        end
        tests_run++;
        if (found == 0) begin fails++; $display("FAIL mid_beat1: got no beat 1 expected one within 10 cycles"); end
        reset_n = 1'b0;
        @(negedge clock);
        tests_run++;
        if (req0 !== 1'b0 || bi0 !== 4'd0 || gc0 !== 16'd0 || done0 !== 1'b0 || to0 !== 1'b0) begin
            fails++; $display("FAIL mid_reset: got req %0b idx %0d gc %0d done %0b to %0b expected 0 0 0 0 0",
                              req0, bi0, gc0, done0, to0);
        end
        reset_n = 1'b1; drv_ack0 = 1'b0; q0.delete(); q1.delete(); exp_gc0 = 0;
        @(negedge clock);
        start_job0(4'd2);
        drv_ack0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bv0) beats++;
            if (done0) dones++;
            if (to0) tos++;
        end
        drv_ack0 = 1'b0;
        exp_gc0 = 2;
        tests_run++;
        if (beats != 2 || dones != 1 || tos != 0) begin
            fails++; $display("FAIL mid_fresh: got beats %0d done %0d to %0d expected 2 1 0", beats, dones, tos);
        end
        tests_run++;
        if (gc0 !== 16'(exp_gc0)) begin fails++; $display("FAIL mid_gc: got %0d expected %0d", gc0, exp_gc0); end
    endtask

    initial begin
        reset_n = 1'b0; arb_mode = 1'b0; drv_ack0 = 1'b0;
        jv0 = 1'b0; jv1 = 1'b0; jl0 = 4'd0; jl1 = 4'd0;
        test_reset();
        test_single();
        test_zero_len();
        test_stale_ack();
        test_timeout();
        test_two_instances();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
